mult_share_arbiter: RTL and testbench

//   Shares one combinational Multiplier_4bit datapath between two requesters.

---
 rtl/mult_share_arbiter_pkg.sv | 17 +
 rtl/mult_share_arbiter_if.sv | 30 +++
 rtl/mult_share_arbiter_mul.sv | 13 +
 rtl/mult_share_arbiter.sv | 86 ++++++++
 tb/tb_mult_share_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter.
package mult_share_arbiter_pkg;

  // Operand width; the product is twice as wide.
  parameter int unsigned WIDTH = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StMul  = S_MUL,
    StOut  = S_OUT
  } state_e;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Request/response bundle between the two clients and the shared multiplier.
interface mult_share_arbiter_if;
  import mult_share_arbiter_pkg::*;

  logic               req0;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   b0;
  logic               req1;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b1;
  logic               gnt0;
  logic               gnt1;
  logic               valid0;
  logic               valid1;
  logic               busy;
  logic [2*WIDTH-1:0] p;

  // Client side: issues requests and operands, observes grants and results.
  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, valid0, valid1, busy, p
  );

  // Arbiter side.
  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, valid0, valid1, busy, p
  );

endinterface

// File: rtl/mult_share_arbiter_mul.sv
// Multiplier_4bit: purely combinational unsigned multiplier shared by both clients.
module mult_share_arbiter_mul
  import mult_share_arbiter_pkg::*;
(
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  // Zero-extend so the multiply is evaluated at full product width.
  assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one multiplier between two requesters.
// One operation every three cycles: IDLE (sample) -> MUL (gnt) -> OUT (valid).
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_arbiter_if.slave  bus
);

  state_e             state_q;
  logic               owner_q;   // requester of the in-flight operation
  logic               last_q;    // requester served most recently
  logic [WIDTH-1:0]   op_a_q;
  logic [WIDTH-1:0]   op_b_q;
  logic [2*WIDTH-1:0] p_q;
  logic               gnt0_q;
  logic               gnt1_q;
  logic               valid0_q;
  logic               valid1_q;
  logic               win1;
  logic [2*WIDTH-1:0] prod_w;

  mult_share_arbiter_mul u_multiplier_4bit (
    .a (op_a_q),
    .b (op_b_q),
    .p (prod_w)
  );

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  always_comb begin
    win1 = bus.req1 & (~bus.req0 | ~last_q);
  end

  // Operation FSM with registered grant/valid pulses and product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      op_a_q   <= '0;
      op_b_q   <= '0;
      p_q      <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.req0 | bus.req1) begin
            owner_q <= win1;
            op_a_q  <= win1 ? bus.a1 : bus.a0;
            op_b_q  <= win1 ? bus.b1 : bus.b0;
            gnt0_q  <= ~win1;
            gnt1_q  <= win1;
            state_q <= StMul;
          end
        end
        StMul: begin
          p_q      <= prod_w;
          valid0_q <= ~owner_q;
          valid1_q <= owner_q;
          state_q  <= StOut;
        end
        StOut: begin
          last_q  <= owner_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.valid0 = valid0_q;
  assign bus.valid1 = valid1_q;
  assign bus.busy   = (state_q != StIdle);
  assign bus.p      = p_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever a valid pulse appears.
module tb_mult_share_arbiter;

  typedef struct {
    bit         who;
    logic [7:0] p;
    int         vcyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  bit   mon_en;
  exp_t sb[$];
  exp_t mon_e;

  mult_share_arbiter_if bus ();

  mult_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit who, input int p, input int vcyc);
    exp_t e;
    e.who  = who;
    e.p    = p[7:0];
    e.vcyc = vcyc;
    sb.push_back(e);
  endtask

  // Monitor: exclusivity on every active pulse, scoreboard pop on every valid.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.gnt0 | bus.gnt1 | bus.valid0 | bus.valid1)
        chk("exclusive", {30'd0, bus.gnt0 & bus.gnt1, bus.valid0 & bus.valid1}, 32'd0);
      if (bus.valid0 | bus.valid1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got p=%0d valid1=%0d, expected no valid", bus.p,
                   bus.valid1);
        end else begin
          mon_e = sb.pop_front();
          chk("valid_owner", {31'd0, bus.valid1}, {31'd0, mon_e.who});
          chk("product", {24'd0, bus.p}, {24'd0, mon_e.p});
          chk("valid_cycle", cyc, mon_e.vcyc);
        end
      end else if (sb.size() > 0 && cyc > sb[0].vcyc) begin
        mon_e = sb.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL missing_valid: got none, expected p=%0d for req%0d at cycle %0d",
                 mon_e.p, mon_e.who, mon_e.vcyc);
      end
    end
  end

  int c;

  initial begin
    cyc    = 0;
    n_cmp  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;

    // 1: reset state
    step();
    step();
    @(negedge clk);
    chk("rst_p", {24'd0, bus.p}, 32'd0);
    chk("rst_gnt", {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
    chk("rst_valid", {30'd0, bus.valid0, bus.valid1}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    mon_en = 1'b1;
    step();
    rst_n = 1'b1;

    // 2: single req0 pulse, 3*5
    step();
    c = cyc;
    bus.req0 = 1'b1; bus.a0 = 4'd3; bus.b0 = 4'd5;
    push(1'b0, 15, c + 2);
    step();
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("t2_gnt0", {30'd0, bus.gnt0, bus.gnt1}, 32'd2);
    chk("t2_busy", {31'd0, bus.busy}, 32'd1);
    step();
    step();
    @(negedge clk);
    chk("t2_busy_done", {31'd0, bus.busy}, 32'd0);

    // 5: reset during MUL discards the op and restores last=1 (req0 wins the tie)
    step();
    c = cyc;
    bus.req0 = 1'b1; bus.a0 = 4'd6; bus.b0 = 4'd6;
    step();
    bus.req0 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_gnt0", {31'd0, bus.gnt0}, 32'd1);
    step();
    @(negedge clk);
    chk("t5_no_valid", {30'd0, bus.valid0, bus.valid1}, 32'd0);
    chk("t5_p", {24'd0, bus.p}, 32'd0);
    chk("t5_busy", {31'd0, bus.busy}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    c = cyc;
    bus.req0 = 1'b1; bus.a0 = 4'd1; bus.b0 = 4'd2;
    bus.req1 = 1'b1; bus.a1 = 4'd3; bus.b1 = 4'd3;
    push(1'b0, 2, c + 2);
    step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("t5_tie_gnt", {30'd0, bus.gnt0, bus.gnt1}, 32'd2);
    step();
    step();

    // 3: both requests held from reset -> 0,1,0,1 every 3 cycles
    rst_n = 1'b0;
    bus.req0 = 1'b1; bus.a0 = 4'd15; bus.b0 = 4'd15;
    bus.req1 = 1'b1; bus.a1 = 4'd2;  bus.b1 = 4'd7;
    step();
    step();
    rst_n = 1'b1;
    c = cyc;
    push(1'b0, 225, c + 2);
    push(1'b1, 14,  c + 5);
    push(1'b0, 225, c + 8);
    push(1'b1, 14,  c + 11);
    while (cyc < c + 12) step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();

    // 4: req1 alone; operand change after grant must not leak into the result
    step();
    c = cyc;
    bus.req1 = 1'b1; bus.a1 = 4'd9; bus.b1 = 4'd4;
    push(1'b1, 36, c + 2);
    step();
    bus.req1 = 1'b0;
    bus.a1 = 4'd0;
    @(negedge clk);
    chk("t4_gnt1", {30'd0, bus.gnt0, bus.gnt1}, 32'd1);
    step();
    step();

    // 6: exhaustive sweep through requester 0
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        c = cyc;
        bus.req0 = 1'b1;
        bus.a0 = a[3:0];
        bus.b0 = b[3:0];
        push(1'b0, a * b, c + 2);
        step();
        bus.req0 = 1'b0;
        step();
        step();
      end
    end

    repeat (5) step();
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
